// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared definitions for the 5-stage MIPS hazard unit:
//   - Tnew encodings (result available N cycles after entering E)
//   - Tuse encodings (operand needed N cycles after D)
//   - Default MDU latencies
//   - Counter-width helper used to size the MDU busy counter
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  // Tnew on entry to E: 0 = PC+8 style (ready now), 1 = ALU result, 2 = load data
  typedef enum logic [1:0] {
    TNEW_PC8 = 2'd0,
    TNEW_CAL = 2'd1,
    TNEW_DM  = 2'd2
  } tnew_e;

  // Tuse: stage in which the operand is consumed, counted from D
  typedef enum logic [1:0] {
    TUSE_D = 2'd0,
    TUSE_E = 2'd1,
    TUSE_M = 2'd2
  } tuse_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//   D-stage request bundle into the hazard unit and its decisions back.
//   master : the pipeline decode stage (drives d_*, receives stall/forwarding)
//   slave  : the hazard unit
//   Signals: d_valid, d_a1/d_a2 (rs/rt), d_use_rs/rt, d_tuse_rs/rt, d_a3, d_tnew,
//            d_md_start, d_md_div, d_md_use -> stall, fwd_rs_sel/rdy,
//            fwd_rt_sel/rdy, mdu_busy
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int TNEW_W = 2,
  parameter int SEL_W  = 2
);
  logic              d_valid;
  logic [4:0]        d_a1;
  logic [4:0]        d_a2;
  logic              d_use_rs;
  logic              d_use_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic [4:0]        d_a3;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic              fwd_rs_rdy;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              fwd_rt_rdy;
  logic              mdu_busy;

  modport master (
    output d_valid, d_a1, d_a2, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs_sel, fwd_rs_rdy, fwd_rt_sel, fwd_rt_rdy, mdu_busy
  );

  modport slave (
    input  d_valid, d_a1, d_a2, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs_sel, fwd_rs_rdy, fwd_rt_sel, fwd_rt_rdy, mdu_busy
  );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
//   Priority match of one D-stage source operand against the in-flight
//   producer entries. Entry index 0 is the E stage; the youngest (lowest
//   index) matching producer shadows older ones.
//   Ports: use_op/addr/tuse (operand), ent_a3/ent_tnew (scoreboard),
//          sel (1-based stage, 0 = register file), rdy, stall_op
// -----------------------------------------------------------------------------
module sb_match #(
  parameter int NSTAGE = 3,
  parameter int TNEW_W = 2,
  parameter int SEL_W  = 2
) (
  input  logic                         use_op,
  input  logic [4:0]                   addr,
  input  logic [TNEW_W-1:0]            tuse,
  input  logic [NSTAGE-1:0][4:0]       ent_a3,
  input  logic [NSTAGE-1:0][TNEW_W-1:0] ent_tnew,
  output logic [SEL_W-1:0]             sel,
  output logic                         rdy,
  output logic                         stall_op
);

  logic [NSTAGE-1:0] hit_s;
  logic [SEL_W-1:0]  sel_s;
  logic [TNEW_W-1:0] win_tnew_s;
  logic              found_s;

  // Scan oldest to youngest so the youngest hit is the last one written
  always_comb begin
    hit_s      = {NSTAGE{1'b0}};
    sel_s      = {SEL_W{1'b0}};
    win_tnew_s = {TNEW_W{1'b0}};
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      // $0 is hard-wired, so it never names a real producer
      hit_s[k]   = use_op & (addr != 5'd0) & (ent_a3[k] == addr);
      sel_s      = hit_s[k] ? SEL_W'(k + 1) : sel_s;
      win_tnew_s = hit_s[k] ? ent_tnew[k] : win_tnew_s;
    end
  end

  assign found_s  = (sel_s != {SEL_W{1'b0}});
  assign sel      = sel_s;
  assign rdy      = found_s & (win_tnew_s == {TNEW_W{1'b0}});
  assign stall_op = found_s & (win_tnew_s > tuse);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the 5-stage MIPS pipeline. Tracks {a3, tnew} of the
//   instructions in the NSTAGE stages after D, decides the D-stage stall,
//   forwarding select/ready per operand, and keeps an MDU busy counter.
//   Ports: clk, rst_n (async active-low), hz (hazard_scoreboard_if.slave)
//   Optional: HAZARD_PERF_EN adds perf_stall_cnt / perf_md_stall_cnt (32-bit,
//   wrapping) counting stall cycles and MDU stall cycles.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  NSTAGE  = 3,
  parameter int  TNEW_W  = 2,
  parameter int  MUL_LAT = MUL_LAT_DEF,
  parameter int  DIV_LAT = DIV_LAT_DEF,
  localparam int SEL_W   = $clog2(NSTAGE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_scoreboard_if.slave    hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_md_stall_cnt
`endif
);

  localparam int CNT_W = cnt_width((DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  // Entry index 0 = E stage, NSTAGE-1 = last stage before RF write
  logic [NSTAGE-1:0][4:0]        a3_q, a3_d;
  logic [NSTAGE-1:0][TNEW_W-1:0] tnew_q, tnew_d;
  logic [CNT_W-1:0]              mdu_cnt_q, mdu_cnt_d;

  logic             stall_rs_s, stall_rt_s, stall_md_s, stall_s;
  logic             issue_s, mdu_busy_s;
  logic [SEL_W-1:0] rs_sel_s, rt_sel_s;
  logic             rs_rdy_s, rt_rdy_s;

  sb_match #(.NSTAGE(NSTAGE), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_match_rs (
    .use_op   (hz.d_use_rs),
    .addr     (hz.d_a1),
    .tuse     (hz.d_tuse_rs),
    .ent_a3   (a3_q),
    .ent_tnew (tnew_q),
    .sel      (rs_sel_s),
    .rdy      (rs_rdy_s),
    .stall_op (stall_rs_s)
  );

  sb_match #(.NSTAGE(NSTAGE), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_match_rt (
    .use_op   (hz.d_use_rt),
    .addr     (hz.d_a2),
    .tuse     (hz.d_tuse_rt),
    .ent_a3   (a3_q),
    .ent_tnew (tnew_q),
    .sel      (rt_sel_s),
    .rdy      (rt_rdy_s),
    .stall_op (stall_rt_s)
  );

  // A start issued this cycle only becomes visible through mdu_cnt_q next cycle
  assign mdu_busy_s = (mdu_cnt_q != {CNT_W{1'b0}});
  assign stall_md_s = hz.d_md_use & mdu_busy_s;
  assign stall_s    = hz.d_valid & (stall_rs_s | stall_rt_s | stall_md_s);
  assign issue_s    = hz.d_valid & ~stall_s;

  // Next scoreboard state: a stalled or empty D injects a bubble into E
  always_comb begin
    a3_d      = a3_q;
    tnew_d    = tnew_q;
    a3_d[0]   = issue_s ? hz.d_a3 : 5'd0;
    tnew_d[0] = issue_s ? hz.d_tnew : {TNEW_W{1'b0}};
    for (int k = 1; k < NSTAGE; k++) begin
      a3_d[k]   = a3_q[k-1];
      // Tnew counts down to zero and sticks there
      tnew_d[k] = (tnew_q[k-1] == {TNEW_W{1'b0}}) ? {TNEW_W{1'b0}}
                                                  : (tnew_q[k-1] - TNEW_W'(1));
    end
  end

  // Next MDU counter: a new start reloads even while still counting down
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (issue_s & hz.d_md_start) begin
      mdu_cnt_d = hz.d_md_div ? DIV_CNT : MUL_CNT;
    end else if (mdu_busy_s) begin
      mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
    end else begin
      mdu_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Scoreboard and MDU counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a3_q      <= '{default: 5'd0};
      tnew_q    <= '{default: {TNEW_W{1'b0}}};
      mdu_cnt_q <= {CNT_W{1'b0}};
    end else begin
      a3_q      <= a3_d;
      tnew_q    <= tnew_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign hz.stall      = stall_s;
  assign hz.fwd_rs_sel = rs_sel_s;
  assign hz.fwd_rs_rdy = rs_rdy_s;
  assign hz.fwd_rt_sel = rt_sel_s;
  assign hz.fwd_rt_rdy = rt_rdy_s;
  assign hz.mdu_busy   = mdu_busy_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_md_stall_cnt_q, perf_md_stall_cnt_d;

  // Free-running event counters, wrapping at 2^32
  always_comb begin
    perf_stall_cnt_d    = perf_stall_cnt_q + (stall_s ? 32'd1 : 32'd0);
    perf_md_stall_cnt_d = perf_md_stall_cnt_q + (stall_md_s ? 32'd1 : 32'd0);
  end

  // Performance counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_q    <= 32'd0;
      perf_md_stall_cnt_q <= 32'd0;
    end else begin
      perf_stall_cnt_q    <= perf_stall_cnt_d;
      perf_md_stall_cnt_q <= perf_md_stall_cnt_d;
    end
  end

  assign perf_stall_cnt    = perf_stall_cnt_q;
  assign perf_md_stall_cnt = perf_md_stall_cnt_q;
`endif

endmodule
